alu_sequencer: RTL

- Initiator side of the 8-bit ALU interface. Accepts 16-bit instructions over a valid/ready handshake.
- Drives A, B and ALU_Sel to the external combinational ALU, then writes ALU_Out into a 4x8 register file and latches the carry/zero/neg flags.
- Supports load-immediate and a flag-conditional skip.
- Sits between the instruction source and the ALU in the datapath.

---
 rtl/alu_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues 16-bit instructions to an external combinational
// 8-bit ALU, writes results into a 4x8 register file, latches the ALU flags,
// and supports load-immediate and a flag-conditional skip of the next
// instruction.
//
// instr format: [15:12] op | [11:10] rd | [9:8] rs | [7:0] imm
//   op 0x0-0x6 : R[rd] <= ALU(R[rd], R[rs]), sel = op[2:0]
//   op 0x7     : LDI   R[rd] <= imm
//   op 0x8-0xE : R[rd] <= ALU(R[rd], imm),   sel = op[2:0]
//   op 0xF     : SKIP  next instruction if |(flags & imm[2:0])
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for an instruction; a pending skip discards the next one
// EXEC  | ALU operands are stable; result/flag write on the leaving edge

module alu_sequencer #(
  parameter int NREG = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [7:0]  A,
  output logic [7:0]  B,
  output logic [2:0]  ALU_Sel,
  input  logic [7:0]  ALU_Out,
  input  logic        carry,
  input  logic        zero,
  input  logic        neg,
  output logic [2:0]  flags,
  input  logic [1:0]  dbg_addr,
  output logic [7:0]  dbg_data,
  output logic        done,
  output logic        skipped
);

  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_SKIP = 4'hF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [7:0]  regs [NREG];
  logic        skip_pending;

  // Fields of the instruction being executed; rs is consumed at acceptance
  // so it is not kept.
  logic [3:0]  ir_op;
  logic [1:0]  ir_rd;
  logic [7:0]  ir_imm;

  // Control strobes from the output decode
  logic        accept;
  logic        take;
  logic        discard;
  logic        retire;

  // Decode of the incoming instruction word
  logic [3:0]  in_op;
  logic [1:0]  in_rd;
  logic [1:0]  in_rs;
  logic [7:0]  in_imm;
  logic        in_is_alu;

  // Decode of the held instruction
  logic        ir_is_alu;
  logic        ir_is_ldi;
  logic        ir_is_skip;

  assign in_op     = instr[15:12];
  assign in_rd     = instr[11:10];
  assign in_rs     = instr[9:8];
  assign in_imm    = instr[7:0];
  assign in_is_alu = (in_op != OP_LDI) && (in_op != OP_SKIP);

  assign ir_is_ldi  = (ir_op == OP_LDI);
  assign ir_is_skip = (ir_op == OP_SKIP);
  assign ir_is_alu  = !ir_is_ldi && !ir_is_skip;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: a discarded instruction never leaves IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (take) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: handshake and datapath strobes
  always_comb begin
    instr_ready = 1'b0;
    retire      = 1'b0;
    case (state)
      ST_IDLE: instr_ready = 1'b1;
      ST_EXEC: retire      = 1'b1;
      default: instr_ready = 1'b0;
    endcase
    accept  = instr_valid && instr_ready;
    take    = accept && !skip_pending;
    discard = accept && skip_pending;
  end

  // Capture the instruction fields needed in EXEC
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_op  <= 4'h0;
      ir_rd  <= 2'd0;
      ir_imm <= 8'h00;
    end else if (take) begin
      ir_op  <= in_op;
      ir_rd  <= in_rd;
      ir_imm <= in_imm;
    end
  end

  // ALU operands are read from the register file at acceptance; LDI and
  // SKIP leave the ALU inputs untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      A       <= 8'h00;
      B       <= 8'h00;
      ALU_Sel <= 3'b000;
    end else if (take && in_is_alu) begin
      A       <= regs[in_rd];
      B       <= in_op[3] ? in_imm : regs[in_rs];
      ALU_Sel <= in_op[2:0];
    end
  end

  // Register file write on the edge leaving EXEC
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= 8'h00;
      end
    end else if (retire) begin
      if (ir_is_alu) begin
        regs[ir_rd] <= ALU_Out;
      end else if (ir_is_ldi) begin
        regs[ir_rd] <= ir_imm;
      end
    end
  end

  // Flags follow only ALU instructions
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= 3'b000;
    end else if (retire && ir_is_alu) begin
      flags <= {neg, zero, carry};
    end
  end

  // SKIP evaluates against the flags latched before it; a discarded
  // instruction (even a SKIP) only clears the pending skip.
  always_ff @(posedge clk) begin
    if (reset) begin
      skip_pending <= 1'b0;
    end else if (discard) begin
      skip_pending <= 1'b0;
    end else if (retire && ir_is_skip) begin
      skip_pending <= |(flags & ir_imm[2:0]);
    end
  end

  // One-cycle status pulses; retire (EXEC) and discard (IDLE) are exclusive
  always_ff @(posedge clk) begin
    if (reset) begin
      done    <= 1'b0;
      skipped <= 1'b0;
    end else begin
      done    <= retire;
      skipped <= discard;
    end
  end

  assign dbg_data = regs[dbg_addr];

endmodule
